wave_period_meter: RTL
======================

Name: wave_period_meter

Overview:
- Downstream consumer of the square-wave generator's `signal` output; runs on the same `clk` domain.
- Measures the high-phase and low-phase durations of each complete period in 100 ns units, giving back the generator's m/n settings.
- Presents each measurement on a valid/ready handshake, with status flags, for a checker or display stage.

Parameters:
- TICK_DIV, 10, clock cycles per measurement unit (10 x 10 ns = 100 ns).
- CW, 8, width of the internal per-phase cycle counter; must satisfy 2^CW > 16*TICK_DIV.

Ports:
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- signal  in  1  generator waveform, synchronous to clk.
- out_ready  in  1  consumer accepts the current result.
- out_valid  out  1  result registers hold an unconsumed measurement.
- m_meas  out  4  high-phase length in units.
- n_meas  out  4  low-phase length in units.
- inexact  out  1  either phase length was not a multiple of TICK_DIV, or was below TICK_DIV.
- sat  out  1  either phase exceeded 15 units; that field is clamped to 15.
- dropped  out  1  sticky: a completed period was discarded because out_valid was still held.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs go to 0.
  - sig_q goes to 0, state goes to SYNC, and all counters clear.
  - Reset mid-period discards any partial measurement. The first measurement after release requires a fresh rising edge.
- Edge detection:
  - sig_q is the registered `signal`.
  - rise = signal & ~sig_q; fall = ~signal & sig_q.
- Phase length L:
  - L is the number of clk rising edges on which the sampled `signal` held the phase level.
  - The cycle counter loads 1 on the edge cycle and increments every cycle while the level holds.
  - The counter saturates at all-ones and never wraps.
- Unit conversion:
  - units = floor(L / TICK_DIV). Implement as a prescale counter 0..TICK_DIV-1 plus a 5-bit unit counter, or as a divide at phase end; either is acceptable if results match.
  - A phase is inexact when L mod TICK_DIV != 0 or units == 0.
  - A phase saturates when units > 15; its field reports 15.
- State machine:
  - SYNC: ignore `signal` until rise. On rise, go to HIGH and start the high count.
  - HIGH: on fall, latch the high result into staging and go to LOW with the low count started.
  - LOW: on rise, the period is complete. Go to HIGH with the count restarted on the same cycle, so there is no dead cycle between periods.
- Result transfer:
  - On the cycle after the period-completing rise, if out_valid is 0 or (out_valid & out_ready):
    - load m_meas, n_meas, inexact and sat;
    - set out_valid = 1.
  - Otherwise drop the period, keep the held result and set `dropped`.
- Handshake:
  - A transfer occurs when out_valid & out_ready at a clk edge.
  - If no new result loads in that same cycle, out_valid clears.
  - Held outputs are stable while out_valid & ~out_ready.
  - `dropped` clears only on reset.
- Simultaneous events: a new result load and consumer acceptance in the same cycle is a transfer followed by a load. out_valid stays 1, the new data appears and `dropped` is not set.
- Constant input: if `signal` stays at one level indefinitely, the counter saturates, no result is produced and no wrap occurs.
- Latency: out_valid rises exactly 2 clk cycles after the `signal` transition that completes the low phase, i.e. one cycle for sig_q plus one result-register cycle.

Test Plan:
1. Reset held for 1 cycle, then `signal` high 10 cycles / low 10 cycles repeating, out_ready=1 -> first result m_meas=1, n_meas=1, inexact=0, sat=0. out_valid pulses once per 20-cycle period, 2 cycles after each low-to-high transition.
2. High 20 / low 20, then switch at a period boundary to high 40 / low 30 -> results 2/2 repeating, then 4/3. No spurious mixed result at the switch.
3. High 25 / low 10 -> m_meas=2, n_meas=1, inexact=1. High 5 / low 10 -> m_meas=0, inexact=1.
4. High 170 / low 10 -> m_meas=15, sat=1, n_meas=1. `signal` stuck high for 5000 cycles -> out_valid stays 0 with no wrap. A following 10/10 period -> 1/1.
5. out_ready=0 across three 10/10 periods -> first result held stable with out_valid=1 and dropped=1. Raising out_ready for 1 cycle coincident with a new result -> out_valid stays 1 with fresh data.
6. Assert reset_n low asynchronously mid-HIGH, between clk edges -> all outputs 0 immediately. After release, a partial high phase is ignored until the next rise, and the next full 10/10 period -> 1/1.

Source files
------------

// File: rtl/wave_period_meter.sv
// wave_period_meter: measures high/low phase lengths of a square wave in TICK_DIV-cycle units
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset, released synchronously inside
//   signal     measured waveform, synchronous to clk
//   out_ready  consumer accepts the presented result
//   out_valid  result registers hold an unconsumed measurement
//   m_meas     high-phase length in units (clamped to 15)
//   n_meas     low-phase length in units (clamped to 15)
//   inexact    a phase was not a whole number of units, or shorter than one unit
//   sat        a phase exceeded 15 units
//   dropped    sticky: a completed period was lost because the held result was not consumed
module wave_period_meter #(
    parameter int TICK_DIV = 10,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       signal,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] m_meas,
    output logic [3:0] n_meas,
    output logic       inexact,
    output logic       sat,
    output logic       dropped
);
    typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

    // {field[3:0], inexact, sat} for a phase of l cycles
    function automatic logic [5:0] conv(input logic [CW-1:0] l);
        logic [CW-1:0] u;
        u = l / CW'(TICK_DIV);
        return {(u > CW'(15)) ? 4'd15 : u[3:0], (l % CW'(TICK_DIV) != '0) || (u == '0), u > CW'(15)};
    endfunction

    logic [1:0]    rst_sync;
    logic          rst_n_i;
    state_t        state;
    logic          sig_q;
    logic          sq_vld;
    logic          pend;
    logic [CW-1:0] cnt;
    logic [5:0]    m_stg;
    logic [9:0]    res_stg;
    logic [5:0]    cur;
    logic          rise;
    logic          fall;

    // assertion is immediate, release lines up with clk
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    assign rst_n_i = rst_sync[1];

    // sig_q's reset value is not a real observation, so no edge is reported
    // until it has captured the line once; a level present at release is not a rise
    assign rise = signal & ~sig_q & sq_vld;
    assign fall = ~signal & sig_q & sq_vld;
    assign cur  = conv(cnt);

    always_ff @(posedge clk or negedge rst_n_i)
        if (!rst_n_i) begin
            state     <= SYNC;
            sig_q     <= 1'b0;
            sq_vld    <= 1'b0;
            pend      <= 1'b0;
            cnt       <= '0;
            m_stg     <= '0;
            res_stg   <= '0;
            out_valid <= 1'b0;
            m_meas    <= '0;
            n_meas    <= '0;
            inexact   <= 1'b0;
            sat       <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            sig_q  <= signal;
            sq_vld <= 1'b1;
            // cnt holds the length of the phase in progress, saturating instead of wrapping
            cnt    <= (rise | fall) ? CW'(1) : (&cnt ? cnt : cnt + CW'(1));
            pend   <= 1'b0;
            case (state)
                SYNC: if (rise) state <= HIGH;
                HIGH: if (fall) begin
                    m_stg <= cur;
                    state <= LOW;
                end
                LOW: if (rise) begin
                    res_stg <= {m_stg[5:2], cur[5:2], m_stg[1] | cur[1], m_stg[0] | cur[0]};
                    pend    <= 1'b1;
                    state   <= HIGH;
                end
                default: state <= SYNC;
            endcase
            // a load in the same cycle as an accept wins: transfer then reload
            if (pend && (!out_valid || out_ready)) begin
                {m_meas, n_meas, inexact, sat} <= res_stg;
                out_valid <= 1'b1;
            end else begin
                if (pend) dropped <= 1'b1;
                if (out_ready) out_valid <= 1'b0;
            end
        end
endmodule
